// File: rtl/voice_mixer.sv
// Sequential voice mixer: accumulates one voice per cycle, shifts, saturates, holds result until accepted.
// Optional clip counter enabled by defining VOICE_MIXER_CLIP_CNT_EN.
module voice_mixer #(
  parameter int NUM_VOICES    = 8,
  parameter int NUM_BITS_WORD = 18
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_tick,
  input  logic [NUM_VOICES*NUM_BITS_WORD-1:0] voice_words,
  input  logic [NUM_VOICES-1:0]               voice_active,
  input  logic [2:0]                          shift,
  input  logic                                mix_ready,
  output logic [NUM_BITS_WORD-1:0]            mix_out,
  output logic                                mix_valid,
  output logic                                busy,
  output logic                                clip,
  output logic                                overrun,
  output logic [15:0]                         clip_count
);

  localparam int W  = NUM_BITS_WORD;
  localparam int IW = $clog2(NUM_VOICES);
  localparam int AW = W + IW;

  localparam logic signed [AW-1:0] SAT_MAX = {{(IW+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(IW+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;

  state_t                       state_q, state_d;
  logic [NUM_VOICES*W-1:0]      voice_q, voice_d;
  logic [NUM_VOICES-1:0]        active_q, active_d;
  logic [2:0]                   shift_q, shift_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic signed [AW-1:0]         acc_q, acc_d;
  logic [W-1:0]                 mix_out_q, mix_out_d;
  logic                         mix_valid_q, mix_valid_d;
  logic                         clip_q, clip_d;
  logic                         overrun_q, overrun_d;

  logic [W-1:0]                 voice_sel;
  logic signed [AW-1:0]         addend;
  logic signed [AW-1:0]         shifted;

  always_comb begin
    state_d     = state_q;
    voice_d     = voice_q;
    active_d    = active_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = mix_valid_q;
    clip_d      = 1'b0;
    // Any tick outside IDLE is lost, including one coinciding with the OUT handshake.
    overrun_d   = sample_tick && (state_q != IDLE);

    voice_sel = voice_q[int'(idx_q)*W +: W];
    addend    = active_q[idx_q] ? {{IW{voice_sel[W-1]}}, voice_sel} : '0;
    shifted   = acc_q >>> shift_q;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          voice_d  = voice_words;
          active_d = voice_active;
          shift_d  = shift;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_VOICES - 1)) begin
          state_d = SAT;
        end
      end
      SAT: begin
        if (shifted > SAT_MAX) begin
          mix_out_d = SAT_MAX[W-1:0];
          clip_d    = 1'b1;
        end else if (shifted < SAT_MIN) begin
          mix_out_d = SAT_MIN[W-1:0];
          clip_d    = 1'b1;
        end else begin
          mix_out_d = shifted[W-1:0];
        end
        mix_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (mix_ready) begin
          mix_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      voice_q     <= '0;
      active_q    <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      voice_q     <= voice_d;
      active_q    <= active_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef VOICE_MIXER_CLIP_CNT_EN
  logic [15:0] clip_count_q, clip_count_d;

  always_comb begin
    clip_count_d = clip_count_q;
    if (clip_d && (clip_count_q != 16'hFFFF)) begin
      clip_count_d = clip_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clip_count_q <= 16'd0;
    end else begin
      clip_count_q <= clip_count_d;
    end
  end

  assign clip_count = clip_count_q;
`else
  assign clip_count = 16'd0;
`endif

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = (state_q != IDLE);
  assign clip      = clip_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: latency, saturation, masking, backpressure, overrun, reset abort, clip count.
module tb_voice_mixer;
  localparam int N = 8;
  localparam int W = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_tick;
  logic [N*W-1:0]   voice_words;
  logic [N-1:0]     voice_active;
  logic [2:0]       shift;
  logic             mix_ready;
  logic [W-1:0]     mix_out;
  logic             mix_valid;
  logic             busy;
  logic             clip;
  logic             overrun;
  logic [15:0]      clip_count;

  int n_cmp = 0;
  int n_bad = 0;

  voice_mixer #(.NUM_VOICES(N), .NUM_BITS_WORD(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .voice_words  (voice_words),
    .voice_active (voice_active),
    .shift        (shift),
    .mix_ready    (mix_ready),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .clip         (clip),
    .overrun      (overrun),
    .clip_count   (clip_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) voice_words[i*W +: W] = v;
  endtask

  // Issue one tick, wait for the result, then accept it with a one-cycle ready.
  task automatic do_sample(input bit scramble, output logic [W-1:0] out, output int lat,
                           output int clips, output int busy_low);
    logic [N*W-1:0] sv_words;
    logic [N-1:0]   sv_active;
    logic [2:0]     sv_shift;
    sv_words = voice_words; sv_active = voice_active; sv_shift = shift;
    clips = 0; busy_low = 0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    lat = 1;
    if (scramble) begin
      voice_words  = {N{18'h15555}};
      voice_active = ~voice_active;
      shift        = shift + 3'd1;
    end
    while (!mix_valid && lat < 40) begin
      if (!busy) busy_low++;
      clips += int'(clip);
      @(posedge clk); #1 lat++;
    end
    if (!mix_valid) lat = -1;
    clips += int'(clip);
    out = mix_out;
    mix_ready = 1'b1;
    @(posedge clk); #1 mix_ready = 1'b0;
    clips += int'(clip);
    voice_words = sv_words; voice_active = sv_active; shift = sv_shift;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mix_out !== '0) begin n_bad++; $display("FAIL reset_mix_out: got %h want 0", mix_out); end
    n_cmp++; if (mix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mix_valid: got %b want 0", mix_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({clip, overrun} !== 2'b00) begin n_bad++; $display("FAIL reset_clip_overrun: got %b want 00", {clip, overrun}); end
    n_cmp++; if (clip_count !== 16'd0) begin n_bad++; $display("FAIL reset_clip_count: got %h want 0", clip_count); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [W-1:0] o; int lat, clips, bl;
    set_all(18'h01000); voice_active = 8'hFF; shift = 3'd3;
    do_sample(1'b0, o, lat, clips, bl);
    n_cmp++; if (o !== 18'h01000) begin n_bad++; $display("FAIL basic_out: got %h want 01000", o); end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL basic_latency: got %0d want 10", lat); end
    n_cmp++; if (clips !== 0) begin n_bad++; $display("FAIL basic_clip: got %0d want 0", clips); end
    n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL basic_busy: busy low %0d cycles, want 0", bl); end
  endtask

  task automatic test_saturation;
    logic [W-1:0] o; int lat, clips, bl;
    set_all(18'h1FFFF); voice_active = 8'hFF; shift = 3'd0;
    do_sample(1'b0, o, lat, clips, bl);
    n_cmp++; if (o !== 18'h1FFFF) begin n_bad++; $display("FAIL sat_pos_out: got %h want 1ffff", o); end
    n_cmp++; if (clips !== 1) begin n_bad++; $display("FAIL sat_pos_clip: got %0d want 1", clips); end
    set_all(18'h20000);
    do_sample(1'b0, o, lat, clips, bl);
    n_cmp++; if (o !== 18'h20000) begin n_bad++; $display("FAIL sat_neg_out: got %h want 20000", o); end
    n_cmp++; if (clips !== 1) begin n_bad++; $display("FAIL sat_neg_clip: got %0d want 1", clips); end
  endtask

  task automatic test_mask;
    logic [W-1:0] o; int lat, clips, bl;
    set_all(18'd5000);
    voice_words[0*W +: W] = 18'd100;
    voice_words[2*W +: W] = 18'h3FFD8;
    voice_active = 8'b0000_0101; shift = 3'd0;
    do_sample(1'b1, o, lat, clips, bl);
    n_cmp++; if (o !== 18'd60) begin n_bad++; $display("FAIL mask_out: got %0d want 60", o); end
    voice_active = 8'h00;
    do_sample(1'b0, o, lat, clips, bl);
    n_cmp++; if (o !== 18'd0) begin n_bad++; $display("FAIL none_active_out: got %h want 0", o); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] held; int unstable, ovr, xfers, waited;
    set_all(18'd7); voice_active = 8'hFF; shift = 3'd0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    waited = 0;
    while (!mix_valid && waited < 40) begin @(posedge clk); #1 waited++; end
    held = mix_out;
    n_cmp++; if (held !== 18'd56) begin n_bad++; $display("FAIL bp_out: got %0d want 56", held); end
    unstable = 0; ovr = 0;
    for (int k = 0; k < 20; k++) begin
      sample_tick = (k == 5);
      if (mix_out !== held || mix_valid !== 1'b1) unstable++;
      ovr += int'(overrun);
      @(posedge clk); #1;
    end
    sample_tick = 1'b0;
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
    n_cmp++; if (ovr !== 1) begin n_bad++; $display("FAIL bp_overrun: got %0d pulses want 1", ovr); end
    mix_ready = 1'b1; xfers = 0;
    for (int k = 0; k < 15; k++) begin
      if (mix_valid && mix_ready) xfers++;
      @(posedge clk); #1;
    end
    mix_ready = 1'b0;
    n_cmp++; if (xfers !== 1) begin n_bad++; $display("FAIL bp_transfers: got %0d want 1", xfers); end
  endtask

  task automatic test_back_to_back;
    int waited, late_valid;
    set_all(18'd3); voice_active = 8'hFF; shift = 3'd0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    waited = 0;
    while (!mix_valid && waited < 40) begin @(posedge clk); #1 waited++; end
    n_cmp++; if (mix_out !== 18'd24) begin n_bad++; $display("FAIL b2b_out: got %0d want 24", mix_out); end
    mix_ready = 1'b1; sample_tick = 1'b1;
    @(posedge clk); #1 mix_ready = 1'b0; sample_tick = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    n_cmp++; if ({mix_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle: valid/busy got %b want 00", {mix_valid, busy}); end
    late_valid = 0;
    for (int k = 0; k < 15; k++) begin
      if (mix_valid || busy) late_valid++;
      @(posedge clk); #1;
    end
    n_cmp++; if (late_valid !== 0) begin n_bad++; $display("FAIL b2b_dropped: got %0d active cycles want 0", late_valid); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] o; int lat, clips, bl, spurious;
    for (int i = 0; i < N; i++) voice_words[i*W +: W] = W'(1000 * (i + 1));
    voice_active = 8'hFF; shift = 3'd1;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if ({mix_valid, busy, clip, overrun} !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags: got %b want 0000", {mix_valid, busy, clip, overrun}); end
    n_cmp++; if (mix_out !== '0) begin n_bad++; $display("FAIL midrst_out: got %h want 0", mix_out); end
    n_cmp++; if (clip_count !== 16'd0) begin n_bad++; $display("FAIL midrst_clip_count: got %h want 0", clip_count); end
    @(posedge clk); #1 rst = 1'b1;
    spurious = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (mix_valid) spurious++;
    end
    n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d valid cycles want 0", spurious); end
    do_sample(1'b0, o, lat, clips, bl);
    n_cmp++; if (o !== 18'd18000) begin n_bad++; $display("FAIL midrst_next_out: got %0d want 18000", o); end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL midrst_next_latency: got %0d want 10", lat); end
  endtask

  task automatic test_clip_count;
    logic [W-1:0] o; int lat, clips, bl, total;
    logic [15:0] want;
    set_all(18'h1FFFF); voice_active = 8'hFF; shift = 3'd0;
    total = 0;
    for (int s = 0; s < 3; s++) begin
      do_sample(1'b0, o, lat, clips, bl);
      total += clips;
    end
    n_cmp++; if (total !== 3) begin n_bad++; $display("FAIL cc_clip_pulses: got %0d want 3", total); end
`ifdef VOICE_MIXER_CLIP_CNT_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    n_cmp++; if (clip_count !== want) begin n_bad++; $display("FAIL cc_count: got %0d want %0d", clip_count, want); end
  endtask

  initial begin
    sample_tick  = 1'b0;
    mix_ready    = 1'b0;
    voice_words  = '0;
    voice_active = '0;
    shift        = 3'd0;
    test_reset;
    test_basic;
    test_saturation;
    test_mask;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_clip_count;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
